// File: rtl/instruction_fetch_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the two buses of the fetch stage:
//   - the instruction-memory request/response bus
//     (imem_address, imem_enable, imem_read, imem_data_in, imem_data_out)
//   - the decode-side valid/ready handshake
//     (out_valid, out_ready, out_instr, out_pc)
// Modports:
//   master : the fetch stage (drives requests and the head of its queue)
//   slave  : the environment (memory + decode)
// ----------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] imem_address;
    logic              imem_enable;
    logic              imem_read;
    logic [DATA_W-1:0] imem_data_in;
    logic [DATA_W-1:0] imem_data_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_address, imem_enable, imem_read, imem_data_in,
        output out_valid, out_instr, out_pc,
        input  imem_data_out, out_ready
    );

    modport slave (
        input  imem_address, imem_enable, imem_read, imem_data_in,
        input  out_valid, out_instr, out_pc,
        output imem_data_out, out_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: holds the PC, issues word-indexed reads to a memory with one
// cycle of read latency, buffers returned words in a 2-entry queue and hands
// {pc, instr} pairs to decode over valid/ready. A redirect loads a new PC and
// flushes both the queue and any in-flight read.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   fetch_en       allow new fetches
//   redirect_valid redirect strobe (highest priority)
//   redirect_pc    new PC, must be < MEM_DEPTH
//   bus            instruction_fetch_if.master (imem bus + decode handshake)
//
// Optional build macro IFETCH_PERF_EN adds:
//   perf_fetch_cnt 32-bit count of issued fetches
//   perf_stall_cnt 32-bit count of cycles with out_valid & !out_ready
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter int                MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    instruction_fetch_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);

    logic [ADDR_W-1:0] pc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic [1:0]        count_r;
    logic              head_r;
    logic              tail_r;
    logic [DATA_W-1:0] fifo_instr_r [0:1];
    logic [ADDR_W-1:0] fifo_pc_r    [0:1];

    logic              out_valid_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [2:0]        credit_s;
    logic [ADDR_W-1:0] pc_inc_s;

    // Handshake, credit check and PC increment with wrap at MEM_DEPTH.
    always_comb begin
        out_valid_s = rst_n & (count_r != 2'd0);
        pop_s       = out_valid_s & bus.out_ready;
        // Entries held plus the one in flight; a pop this cycle frees a slot.
        credit_s    = {1'b0, count_r} + {2'b00, inflight_r};
        issue_s     = rst_n & fetch_en & ~redirect_valid &
                      (credit_s < (3'd2 + {2'b00, pop_s}));
        push_s      = inflight_r & ~redirect_valid;
        if (pc_r == LAST_PC) begin
            pc_inc_s = {ADDR_W{1'b0}};
        end else begin
            pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // PC, in-flight tracking and queue state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
            count_r       <= 2'd0;
            head_r        <= 1'b0;
            tail_r        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_instr_r[i] <= {DATA_W{1'b0}};
                fifo_pc_r[i]    <= {ADDR_W{1'b0}};
            end
        end else if (redirect_valid) begin
            // Any response arriving now belongs to the old path and is dropped.
            pc_r       <= redirect_pc;
            inflight_r <= 1'b0;
            count_r    <= 2'd0;
            head_r     <= 1'b0;
            tail_r     <= 1'b0;
        end else begin
            if (issue_s) begin
                pc_r          <= pc_inc_s;
                inflight_r    <= 1'b1;
                inflight_pc_r <= pc_r;
            end else begin
                inflight_r    <= 1'b0;
            end
            if (push_s) begin
                fifo_instr_r[tail_r] <= bus.imem_data_out;
                fifo_pc_r[tail_r]    <= inflight_pc_r;
                tail_r               <= ~tail_r;
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end else begin
                head_r <= head_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    assign bus.imem_enable  = issue_s;
    assign bus.imem_address = pc_r;
    assign bus.imem_read    = 1'b1;
    assign bus.imem_data_in = {DATA_W{1'b0}};
    assign bus.out_valid    = out_valid_s;
    // Head registers are forced to zero while reset is held low.
    assign bus.out_instr    = rst_n ? fifo_instr_r[head_r] : {DATA_W{1'b0}};
    assign bus.out_pc       = rst_n ? fifo_pc_r[head_r]    : {ADDR_W{1'b0}};

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_stall_r;

    // Free-running issue and backpressure counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_r <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (issue_s) begin
                perf_fetch_r <= perf_fetch_r + 32'd1;
            end else begin
                perf_fetch_r <= perf_fetch_r;
            end
            if (out_valid_s && !bus.out_ready) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_r;
    assign perf_stall_cnt = perf_stall_r;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. Memory model returns 0x1000 + address
// one cycle after an enabled read. A second instance starts at RESET_PC=1022
// to exercise PC wrap.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_en_w;
    logic        redirect_valid_w;
    logic [63:0] redirect_pc_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_if #(.ADDR_W(64), .DATA_W(64)) bus_m ();
    instruction_fetch_if #(.ADDR_W(64), .DATA_W(64)) bus_w ();

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_m, perf_stall_m, perf_fetch_w, perf_stall_w;
`endif

    instruction_fetch #(
        .ADDR_W(64), .DATA_W(64), .RESET_PC(64'd0), .MEM_DEPTH(1024)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bus(bus_m)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_m), .perf_stall_cnt(perf_stall_m)
`endif
    );

    instruction_fetch #(
        .ADDR_W(64), .DATA_W(64), .RESET_PC(64'd1022), .MEM_DEPTH(1024)
    ) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .bus(bus_w)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_w), .perf_stall_cnt(perf_stall_w)
`endif
    );

    // Registered-read instruction memories.
    always_ff @(posedge clk) begin
        if (bus_m.imem_enable) bus_m.imem_data_out <= 64'h1000 + bus_m.imem_address;
        if (bus_w.imem_enable) bus_w.imem_data_out <= 64'h1000 + bus_w.imem_address;
    end

    typedef struct {
        logic        fe;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        en;
        logic [63:0] addr;
        logic        ov;
        logic [63:0] opc;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fe, input logic rv, input logic [63:0] rpc, input logic rdy);
        @(negedge clk);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        bus_m.out_ready = rdy;
        #1;
    endtask

    initial begin
        int n_issue;
        rst_n = 1'b0;
        fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0;
        bus_m.out_ready = 1'b1;
        fetch_en_w = 1'b1; redirect_valid_w = 1'b0; redirect_pc_w = 64'd0;
        bus_w.out_ready = 1'b1;

        //             fe    rv    rpc     rdy   en    addr    ov    opc
        vecs[0]  = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h0,  1'b0, 64'h0};
        vecs[1]  = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h1,  1'b0, 64'h0};
        vecs[2]  = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h2,  1'b1, 64'h0};
        vecs[3]  = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b1, 64'h1};
        vecs[4]  = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b1, 64'h1};
        vecs[5]  = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b1, 64'h1};
        vecs[6]  = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h3,  1'b1, 64'h1};
        vecs[7]  = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h4,  1'b1, 64'h2};
        vecs[8]  = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b1, 64'h3};
        vecs[9]  = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h5,  1'b1, 64'h3};
        vecs[10] = '{1'b1, 1'b1, 64'h40, 1'b0, 1'b0, 64'h0,  1'b1, 64'h4};
        vecs[11] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h40, 1'b0, 64'h0};
        vecs[12] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h41, 1'b0, 64'h0};
        vecs[13] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h42, 1'b1, 64'h40};
        vecs[14] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1, 64'h41};
        vecs[15] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1, 64'h42};
        vecs[16] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b0, 64'h0};
        vecs[17] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 64'h43, 1'b0, 64'h0};

        // Reset held for two edges with fetch requested.
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        check("rst_imem_enable", {63'd0, bus_m.imem_enable}, 64'd0);
        check("rst_out_valid",   {63'd0, bus_m.out_valid},   64'd0);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        check("rst_out_pc",      bus_m.out_pc,    64'd0);
        check("rst_out_instr",   bus_m.out_instr, 64'd0);
        check("rst_wrap_valid",  {63'd0, bus_w.out_valid}, 64'd0);

        // Table: startup, backpressure, release, redirect, fetch_en low.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i != 0) @(negedge clk);
            fetch_en        = vecs[i].fe;
            redirect_valid  = vecs[i].rv;
            redirect_pc     = vecs[i].rpc;
            bus_m.out_ready = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_imem_enable", i), {63'd0, bus_m.imem_enable}, {63'd0, vecs[i].en});
            if (vecs[i].en)
                check($sformatf("v%0d_imem_address", i), bus_m.imem_address, vecs[i].addr);
            check($sformatf("v%0d_out_valid", i), {63'd0, bus_m.out_valid}, {63'd0, vecs[i].ov});
            if (vecs[i].ov) begin
                check($sformatf("v%0d_out_pc", i), bus_m.out_pc, vecs[i].opc);
                check($sformatf("v%0d_out_instr", i), bus_m.out_instr, 64'h1000 + vecs[i].opc);
            end
        end

        // One-cycle reset in the middle of a stream.
        @(negedge clk);
        rst_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0; bus_m.out_ready = 1'b1;
        #1;
        check("mid_rst_imem_enable", {63'd0, bus_m.imem_enable}, 64'd0);
        check("mid_rst_out_valid",   {63'd0, bus_m.out_valid},   64'd0);
        check("mid_rst_out_pc",      bus_m.out_pc,    64'd0);
        check("mid_rst_out_instr",   bus_m.out_instr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("restart_imem_enable", {63'd0, bus_m.imem_enable}, 64'd1);
        check("restart_address",     bus_m.imem_address, 64'd0);
        check("restart_out_valid",   {63'd0, bus_m.out_valid}, 64'd0);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        check("restart_address_1",   bus_m.imem_address, 64'd1);
        check("restart_out_valid_1", {63'd0, bus_m.out_valid}, 64'd0);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        check("restart_out_valid_2", {63'd0, bus_m.out_valid}, 64'd1);
        check("restart_out_pc",      bus_m.out_pc,    64'd0);
        check("restart_out_instr",   bus_m.out_instr, 64'h1000);
        // Wrap instance restarted from 1022 on the same reset.
        check("wrap_valid_0", {63'd0, bus_w.out_valid}, 64'd1);
        check("wrap_pc_0",    bus_w.out_pc,    64'd1022);
        check("wrap_instr_0", bus_w.out_instr, 64'h1000 + 64'd1022);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        check("wrap_pc_1",    bus_w.out_pc,    64'd1023);
        check("wrap_instr_1", bus_w.out_instr, 64'h1000 + 64'd1023);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        check("wrap_pc_2",    bus_w.out_pc,    64'd0);
        check("wrap_instr_2", bus_w.out_instr, 64'h1000);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        check("wrap_valid_3", {63'd0, bus_w.out_valid}, 64'd1);
        check("wrap_pc_3",    bus_w.out_pc,    64'd1);

        // 10 issues then 4 backpressured cycles, then drain.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_issue = 0;
        for (int c = 0; c < 18; c++) begin
            if (c != 0) @(negedge clk);
            fetch_en        = (c < 10);
            bus_m.out_ready = !(c >= 10 && c < 14);
            #1;
            if (bus_m.imem_enable) n_issue++;
        end
        check("perf_seq_issues", 64'(n_issue), 64'd10);
        check("perf_seq_drained", {63'd0, bus_m.out_valid}, 64'd0);
`ifdef IFETCH_PERF_EN
        check("perf_fetch_cnt", {32'd0, perf_fetch_m}, 64'd10);
        check("perf_stall_cnt", {32'd0, perf_stall_m}, 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
